// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for N requesters with a registered one-hot grant.
// A contended holder may keep its grant for up to HOLD consecutive cycles
// before rotation to the next requester is forced.
module rr_arbiter_n #(
  parameter int N    = 32,
  parameter int HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 grant_valid
);

  localparam int IdW  = $clog2(N);
  localparam int CntW = $clog2(HOLD + 1);

  logic [N-1:0]    grant_q, grant_d;
  logic [IdW-1:0]  id_q, id_d;
  logic            valid_q, valid_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0] hold_q, hold_d;

  logic [N-1:0]    cand;
  logic [IdW-1:0]  start;
  logic [IdW-1:0]  sel;
  logic            found;
  logic            others;
  logic            take_new;
  int              s;

  // While a grant is held ptr equals the holder, so every search starts at ptr+1.
  // The current holder is masked out, which covers both RELEASE and forced rotation.
  always_comb begin
    cand   = req & ~grant_q;
    others = |cand;
    start  = (ptr_q == IdW'(N - 1)) ? '0 : ptr_q + IdW'(1);
    found  = 1'b0;
    sel    = '0;
    s      = 0;
    // Scan from far to near so the nearest match wins.
    for (int k = N - 1; k >= 0; k--) begin
      s = int'(start) + k;
      if (s >= N) s = s - N;
      if (cand[IdW'(s)]) begin
        found = 1'b1;
        sel   = IdW'(s);
      end
    end
  end

  // Choose between IDLE, RELEASE, SOLO and CONTENDED and form next state.
  always_comb begin
    grant_d  = grant_q;
    id_d     = id_q;
    valid_d  = valid_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    take_new = 1'b0;

    if (!valid_q) begin
      take_new = 1'b1;
    end else if (!req[ptr_q]) begin
      take_new = 1'b1;
    end else if (!others || (hold_q < CntW'(HOLD))) begin
      if (hold_q < CntW'(HOLD)) hold_d = hold_q + CntW'(1);
    end else begin
      take_new = 1'b1;
    end

    if (take_new) begin
      if (found) begin
        grant_d      = '0;
        grant_d[sel] = 1'b1;
        id_d         = sel;
        valid_d      = 1'b1;
        ptr_d        = sel;
        hold_d       = CntW'(1);
      end else begin
        grant_d = '0;
        id_d    = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    end
  end

  // State registers; reset clears outputs immediately and parks ptr at N-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= IdW'(N - 1);
      hold_q  <= '0;
    end else begin
      grant_q <= grant_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign grant_valid = valid_q;

endmodule
